// File: rtl/multicycle_control_fsm.sv
// Multicycle processor control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory wait timeout and a sticky FAULT state left only through reset.
module multicycle_control_fsm #(
   parameter int OPCODE_W = 4,
   parameter int WAIT_MAX = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                ir_write,
   output logic                reg_write,
   output logic                mem_read,
   output logic                mem_write,
   output logic                alu_src,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                jump,
   output logic                branch_taken,
   output logic [1:0]          alu_op,
   output logic [2:0]          state,
   output logic                instr_done,
   output logic                fault
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_FAULT  = 3'd5;

   localparam logic [2:0] C_LW  = 3'd0;
   localparam logic [2:0] C_SW  = 3'd1;
   localparam logic [2:0] C_DP  = 3'd2;
   localparam logic [2:0] C_BEQ = 3'd3;
   localparam logic [2:0] C_BNE = 3'd4;
   localparam logic [2:0] C_J   = 3'd5;
   localparam logic [2:0] C_ILL = 3'd6;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

   logic [2:0]          state_q;
   logic [2:0]          state_d;
   logic [OPCODE_W-1:0] op_q;
   logic [CNT_W-1:0]    wait_cnt;
   logic [2:0]          cls_q;
   logic                timeout;

   // Any value above 13 (including nonzero bits above bit 3) is illegal.
   function automatic logic [2:0] op_class(input logic [OPCODE_W-1:0] op);
      logic [2:0] c;
      if (op > OPCODE_W'(13))                          c = C_ILL;
      else if (op == OPCODE_W'(0))                     c = C_LW;
      else if (op == OPCODE_W'(1))                     c = C_SW;
      else if (op <= OPCODE_W'(10))                    c = C_DP;
      else if (op == OPCODE_W'(11))                    c = C_BEQ;
      else if (op == OPCODE_W'(12))                    c = C_BNE;
      else                                             c = C_J;
      return c;
   endfunction

   assign cls_q   = op_class(op_q);
   assign timeout = !mem_ready && (wait_cnt == WAIT_LAST);
   assign state   = state_q;

   always_comb begin
      state_d      = state_q;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      alu_src      = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      jump         = 1'b0;
      branch_taken = 1'b0;
      alu_op       = 2'b00;
      instr_done   = 1'b0;
      fault        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: begin
            case (op_class(opcode))
               C_ILL: state_d = S_FAULT;
               C_J: begin
                  jump       = 1'b1;
                  pc_write   = 1'b1;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls_q)
               C_LW, C_SW: begin
                  alu_src = 1'b1;
                  alu_op  = 2'b10;
                  state_d = S_MEM;
               end
               C_DP: state_d = S_WB;
               C_BEQ, C_BNE: begin
                  alu_op       = 2'b01;
                  branch_taken = (cls_q == C_BEQ) ? zero : !zero;
                  pc_write     = branch_taken;
                  instr_done   = 1'b1;
                  state_d      = S_FETCH;
               end
               default: state_d = S_FAULT;
            endcase
         end
         S_MEM: begin
            if (cls_q == C_LW || cls_q == C_SW) begin
               mem_read  = (cls_q == C_LW);
               mem_write = (cls_q == C_SW);
               // Completion in the final wait cycle still beats the timeout.
               if (mem_ready) begin
                  instr_done = (cls_q == C_SW);
                  state_d    = (cls_q == C_LW) ? S_WB : S_FETCH;
               end else if (timeout) begin
                  state_d = S_FAULT;
               end
            end else begin
               state_d = S_FAULT;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            mem_to_reg = (cls_q == C_LW);
            reg_dst    = (cls_q == C_DP);
            state_d    = S_FETCH;
         end
         S_FAULT: fault = 1'b1;
         default: begin
            fault   = 1'b1;
            state_d = S_FAULT;
         end
      endcase
      // Reset silences every strobe immediately, not just at the next edge.
      if (!rst_n) begin
         pc_write     = 1'b0;
         ir_write     = 1'b0;
         reg_write    = 1'b0;
         mem_read     = 1'b0;
         mem_write    = 1'b0;
         alu_src      = 1'b0;
         reg_dst      = 1'b0;
         mem_to_reg   = 1'b0;
         jump         = 1'b0;
         branch_taken = 1'b0;
         alu_op       = 2'b00;
         instr_done   = 1'b0;
         fault        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         op_q     <= '0;
         wait_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= opcode;
         if (state_d != state_q)
            wait_cnt <= '0;
         else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 Parameter OPCODE_W, default 4: opcode width; must be at least 4.
REQ-002 Parameter WAIT_MAX, default 15: maximum cycles the FSM waits for mem_ready in FETCH or MEM before it faults; must be at least 1.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active low.
REQ-005 opcode  in  OPCODE_W  opcode field of the instruction register.
REQ-006 zero  in  1  ALU zero flag; valid in EXEC.
REQ-007 mem_ready  in  1  memory handshake; the access completes in any cycle where this is 1 while mem_read or mem_write is 1.
REQ-008 pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  write and access strobes.
REQ-009 alu_src, reg_dst, mem_to_reg, jump, branch_taken  out  1 each  datapath selects.
REQ-010 alu_op  out  2  00 = funct/data op, 01 = subtract for compare, 10 = add for address.
REQ-011 state  out  3  current state encoding.
REQ-012 instr_done  out  1  one-cycle pulse per retired instruction.
REQ-013 fault  out  1  sticky error flag.

Function
REQ-014 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5; codes 6 and 7 are unreachable and force the FSM to FAULT.
REQ-015 Outputs are combinational from state, latched opcode op_q, zero and mem_ready; every output not listed for a state is 0.
REQ-016 Opcode classes: 0 = LW, 1 = SW, 2..10 = data-processing, 11 = BEQ, 12 = BNE, 13 = J; 14, 15, and any value with nonzero bits above bit 3, are illegal.
REQ-017 FETCH: mem_read=1.
  - When mem_ready=1: ir_write=1 and pc_write=1; next state DECODE.
  - Otherwise the FSM stays in FETCH.
REQ-018 DECODE: op_q captures opcode.
  - Illegal opcode: next state FAULT.
  - J: jump=1, pc_write=1, instr_done=1; next state FETCH.
  - Any other opcode: next state EXEC.
REQ-019 EXEC outputs by class:
  - LW or SW: alu_src=1, alu_op=10; next state MEM.
  - Data-processing: alu_op=00; next state WB.
  - BEQ/BNE: alu_op=01.
REQ-020 EXEC branch behaviour: branch_taken = (BEQ and zero) or (BNE and not zero); pc_write = branch_taken; instr_done=1; next state FETCH.
REQ-021 MEM: mem_read=1 for LW, mem_write=1 for SW; the FSM stays in MEM until mem_ready=1.
  - LW on completion: next state WB.
  - SW on completion: instr_done=1; next state FETCH.
REQ-022 WB: reg_write=1 and instr_done=1; next state FETCH.
  - LW: mem_to_reg=1, reg_dst=0.
  - Data-processing: mem_to_reg=0, reg_dst=1.
REQ-023 Wait counter: WAIT_MAX-wide range, width clog2(WAIT_MAX+1).
  - Clears on every state change.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - Reaching WAIT_MAX with mem_ready=0 sends the FSM to FAULT; mem_ready=1 in that same cycle wins (normal completion).
REQ-024 FAULT: fault=1 and all strobes 0; exit only by reset.
REQ-025 Opcode input changes after DECODE have no effect until the next DECODE.
REQ-026 Latency, zero-wait memory: J=2 cycles, branch=3, data-processing=4, SW=4, LW=5, each counted from FETCH entry to the next FETCH entry.

Reset
REQ-027 rst_n low asynchronously sets state=FETCH, op_q=0, wait counter=0 and fault=0, and forces every output to 0.
REQ-028 The first rising edge after rst_n rises begins a normal FETCH.
REQ-029 Reset asserted mid-instruction abandons it: no instr_done and no further strobes.

Verification
REQ-030 Reset, then LW with mem_ready=1 throughout -> states 0,1,2,3,4; in WB reg_write=1, mem_to_reg=1; instr_done pulses once in cycle 5.
REQ-031 opcode=4'b0101, zero-wait memory -> in EXEC alu_op=00; in WB reg_dst=1, reg_write=1; 4 cycles per instruction.
REQ-032 BEQ with zero=1, then BNE with zero=1 -> first: branch_taken=1, pc_write=1 in EXEC; second: branch_taken=0, pc_write=0.
REQ-033 SW with mem_ready held 0 in MEM for 3 cycles then 1 -> mem_write=1 for 4 cycles, then FETCH, no fault; the same test with mem_ready held 0 for 15 cycles -> state=5, fault=1.
REQ-034 opcode=4'b1110 in DECODE -> state=5, fault=1, all strobes 0 until rst_n low.
REQ-035 rst_n pulsed low while in MEM with mem_write=1 -> mem_write drops to 0 immediately, state=0, no instr_done.
